// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning the HI/LO registers; multi-cycle ops behind a busy flag.
// Optional multiply-accumulate (madd/maddu/msub) is built only when MULDIV_MACC_EN is defined.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        outputSel,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state  | meaning
  // S_IDLE | ready; accepts start, setHI/setLO write directly
  // S_BUSY | operation in flight, cnt_q counts remaining cycles, commit when it hits 0
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_SETHI = 4'd5;
  localparam logic [3:0] OP_SETLO = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // One shared 64-bit multiplier and one magnitude divider serve signed and unsigned forms.
  always_comb begin
    is_signed = (ctrl == OP_MULT) || (ctrl == OP_DIV) || (ctrl == OP_MADD) || (ctrl == OP_MSUB);
    a_ext = {(is_signed ? {32{opA[31]}} : 32'd0), opA};
    b_ext = {(is_signed ? {32{opB[31]}} : 32'd0), opB};
    prod  = a_ext * b_ext;
    a_neg = is_signed & opA[31];
    b_neg = is_signed & opB[31];
    a_mag = a_neg ? (32'd0 - opA) : opA;
    b_mag = b_neg ? (32'd0 - opB) : opB;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            unique case (ctrl)
              OP_MULT, OP_MULTU: begin
                {pend_hi_d, pend_lo_d} = prod;
                cnt_d   = MUL_CNT;
                state_d = S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero still runs the full latency but commits the old HI/LO.
                if (opB == 32'd0) {pend_hi_d, pend_lo_d} = {hi_q, lo_q};
                else              {pend_hi_d, pend_lo_d} = {rem, quot};
                cnt_d   = DIV_CNT;
                state_d = S_BUSY;
              end
              OP_SETHI: hi_d = opA;
              OP_SETLO: lo_d = opA;
`ifdef MULDIV_MACC_EN
              OP_MADD, OP_MADDU: begin
                {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod;
                cnt_d   = MUL_CNT;
                state_d = S_BUSY;
              end
              OP_MSUB: begin
                {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod;
                cnt_d   = MUL_CNT;
                state_d = S_BUSY;
              end
`endif
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = outputSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random ops against an arithmetic model.
module tb_mul_div_unit;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] opA, opB;
  logic        outputSel;
  logic        cancel;
  logic        busy;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};

  mul_div_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .opA(opA), .opB(opB),
    .outputSel(outputSel), .cancel(cancel), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one op: busy cycles and resulting {HI,LO}.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic [63:0] hl);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, cur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    cur = {m_hi, m_lo};
    cyc = 0;
    hl = cur;
    case (c)
      4'd1: begin cyc = MULC; hl = sa * sb; end
      4'd2: begin cyc = MULC; hl = ua * ub; end
      4'd3: begin
        cyc = DIVC;
        if (b != 0) begin q = sa / sb; r = sa % sb; hl = {r[31:0], q[31:0]}; end
      end
      4'd4: begin
        cyc = DIVC;
        if (b != 0) begin q = longint'(ua / ub); r = longint'(ua % ub); hl = {r[31:0], q[31:0]}; end
      end
      4'd5: hl = {a, m_lo};
      4'd6: hl = {m_hi, a};
`ifdef MULDIV_MACC_EN
      4'd7: begin cyc = MULC; hl = cur + sa * sb; end
      4'd8: begin cyc = MULC; hl = cur + ua * ub; end
      4'd9: begin cyc = MULC; hl = cur - sa * sb; end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Called at posedge+1: present op, then follow busy until it drops.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc, n;
    logic [63:0] hl;
    logic sel;
    model(c, a, b, cyc, hl);
    sel = 1'($urandom_range(0, 1));
    start = 1'b1; ctrl = c; opA = a; opB = b; outputSel = sel;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 4'd0;
    if (cyc > 0) chk({tag, " pending hidden"}, {hi, lo}, {m_hi, m_lo});
    n = 0;
    while (busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, " busy cycles"}, 64'(n), 64'(cyc));
    chk({tag, " hi"}, 64'(hi), 64'(hl[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(hl[31:0]));
    chk({tag, " result"}, 64'(result), 64'(sel ? hl[63:32] : hl[31:0]));
    m_hi = hl[63:32];
    m_lo = hl[31:0];
  endtask

  initial begin
    int cyc, n;
    logic [63:0] hl;
    logic [31:0] e_hi, e_lo;
    reset = 1'b0; start = 1'b0; ctrl = 4'd0; opA = 32'd0; opB = 32'd0; outputSel = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(4'd5, 32'h12345678, 32'd0, "setHI");
    chk("setHI const", 64'(hi), 64'h12345678);

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, "mult");
    chk("mult const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, "multu");
    chk("multu const", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div");
    chk("div const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    chk("div ovf const", {hi, lo}, 64'h00000000_80000000);
    run_op(4'd5, 32'hA5, 32'd0, "preHI");
    run_op(4'd6, 32'hA5, 32'd0, "preLO");
    run_op(4'd4, 32'd7, 32'd0, "divu0");
    chk("divu0 const", {hi, lo}, 64'h000000A5_000000A5);

    run_op(4'd5, 32'd0, 32'd0, "mHI");
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, "mLO");
    run_op(4'd7, 32'd1, 32'd1, "madd");
`ifdef MULDIV_MACC_EN
    e_hi = 32'd1; e_lo = 32'd0;
`else
    e_hi = 32'd0; e_lo = 32'hFFFFFFFF;
`endif
    chk("madd const", {hi, lo}, {e_hi, e_lo});
    run_op(4'd5, 32'd0, 32'd0, "sHI");
    run_op(4'd6, 32'd0, 32'd0, "sLO");
    run_op(4'd9, 32'd1, 32'd1, "msub");
`ifdef MULDIV_MACC_EN
    e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFF;
`else
    e_hi = 32'd0; e_lo = 32'd0;
`endif
    chk("msub const", {hi, lo}, {e_hi, e_lo});

    // Cancel on third busy cycle; the op must never commit.
    run_op(4'd6, 32'h1111, 32'd0, "cLO");
    start = 1'b1; ctrl = 4'd1; opA = 32'd3; opB = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    chk("cancel busy1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    chk("cancel busy drop", 64'(busy), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("cancel hilo kept", {hi, lo}, {m_hi, m_lo});

    // Cancel coincident with start.
    start = 1'b1; cancel = 1'b1; ctrl = 4'd2; opA = 32'd9; opB = 32'd9;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    chk("cancel+start busy", 64'(busy), 64'd0);
    chk("cancel+start hilo", {hi, lo}, {m_hi, m_lo});
    start = 1'b1; cancel = 1'b1; ctrl = 4'd5; opA = 32'hBAD;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    chk("cancel+setHI", 64'(hi), 64'(m_hi));

    // Cancel on the commit edge wins.
    start = 1'b1; ctrl = 4'd1; opA = 32'd5; opB = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (MULC - 1) @(posedge clk);
    #1;
    chk("commit edge busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    chk("cancel at commit busy", 64'(busy), 64'd0);
    chk("cancel at commit hilo", {hi, lo}, {m_hi, m_lo});

    // setLO while busy is ignored.
    model(4'd1, 32'h00010001, 32'h00020003, cyc, hl);
    start = 1'b1; ctrl = 4'd1; opA = 32'h00010001; opB = 32'h00020003;
    @(posedge clk); #1;
    ctrl = 4'd6; opA = 32'hDEADBEEF;
    @(posedge clk); #1; start = 1'b0;
    n = 2;
    while (busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("setLO in busy cycles", 64'(n), 64'(MULC + 1));
    chk("setLO in busy hilo", {hi, lo}, hl);
    m_hi = hl[63:32]; m_lo = hl[31:0];

    // Back-to-back: issued in first non-busy cycle; next edge must raise busy.
    run_op(4'd1, 32'd7, 32'd8, "b2b first");
    run_op(4'd2, 32'hFFFF0000, 32'h10, "b2b second");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      if ((c == 4'd3 || c == 4'd4) && $urandom_range(0, 5) == 0) b = 32'd0;
      run_op(c, a, b, $sformatf("rand%0d op%0d", i, c));
    end

    // Asynchronous reset mid-operation.
    start = 1'b1; ctrl = 4'd3; opA = 32'd100; opB = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset hilo", {hi, lo}, 64'd0);
    chk("async reset result", 64'(result), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset idle", 64'(busy), 64'd0);
    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "post reset mult");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
